// File: rtl/fib_07_unwind.sv
// Unwinds a consistent (a, b) total pair toward zero in n steps of (-1,-2) or (-2,-1),
// preferring the selector's step and falling back to the other one; ends in DONE or ERR.
module fib_07_unwind #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic             selector,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] i,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_i;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH+1:0] w_sumIn;
  logic [WIDTH+1:0] w_tripleN;
  logic             w_ok;
  logic             w_canS1;
  logic             w_canS0;
  logic             w_useS1;

  // Two extra bits keep both a_in+b_in and 3*n_in exact at full input range.
  assign w_sumIn   = {2'b00, a_in} + {2'b00, b_in};
  assign w_tripleN = {1'b0, n_in, 1'b0} + {2'b00, n_in};
  assign w_ok      = (w_sumIn == w_tripleN);

  assign w_canS1 = (r_a >= WIDTH'(1)) && (r_b >= WIDTH'(2));
  assign w_canS0 = (r_a >= WIDTH'(2)) && (r_b >= WIDTH'(1));
  assign w_useS1 = selector ? w_canS1 : !w_canS0;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (r_i == '0) begin
          w_nextState = DONE;
        end else if (!w_canS1 && !w_canS0) begin
          w_nextState = ERR;
        end
      end
      default: begin
        if (start) begin
          w_nextState = w_ok ? RUN : ERR;
        end
      end
    endcase
  end

  // Flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_i     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState == RUN);
      r_done  <= (w_nextState == DONE);
      r_err   <= (w_nextState == ERR);
      case (r_state)
        RUN: begin
          if ((r_i != '0) && (w_canS1 || w_canS0)) begin
            if (w_useS1) begin
              r_a <= r_a - WIDTH'(1);
              r_b <= r_b - WIDTH'(2);
            end else begin
              r_a <= r_a - WIDTH'(2);
              r_b <= r_b - WIDTH'(1);
            end
            r_i <= r_i - WIDTH'(1);
          end
        end
        default: begin
          if (start) begin
            r_a <= a_in;
            r_b <= b_in;
            r_n <= n_in;
            r_i <= n_in;
          end
        end
      endcase
    end
  end

  assign a    = r_a;
  assign b    = r_b;
  assign n    = r_n;
  assign i    = r_i;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_fib_07_unwind.sv
// Directed scenario bench for fib_07_unwind; each task drives one scenario and checks inline.
module tb_fib_07_unwind;

  localparam int W = 11;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] n_in;
  logic         selector;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic [W-1:0] i;
  logic         busy;
  logic         done;
  logic         err;

  int errCount;
  int checkCount;

  fib_07_unwind #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .n_in(n_in),
    .selector(selector), .a(a), .b(b), .n(n), .i(i),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int av, input int bv, input int nv, input logic sel);
    a_in     = W'(av);
    b_in     = W'(bv);
    n_in     = W'(nv);
    selector = sel;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checkCount++;
    if ({a, b, n, i} !== {4 * W{1'b0}} || {busy, done, err} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL reset: a=%0d b=%0d n=%0d i=%0d flags=%b, required all 0", a, b, n, i, {busy, done, err});
    end
    rst = 1'b0;
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b000 || a !== 0) begin
      errCount++;
      $display("[TB] FAIL idle_hold: flags=%b a=%0d, required 000 a=0", {busy, done, err}, a);
    end
  endtask

  task automatic test_long_run();
    applyStimulus(300, 300, 200, 1'b1);
    checkCount++;
    if (busy !== 1'b1 || a !== 300 || b !== 300 || n !== 200 || i !== 200) begin
      errCount++;
      $display("[TB] FAIL long_load: busy=%b a=%0d b=%0d n=%0d i=%0d, required 1 300 300 200 200", busy, a, b, n, i);
    end
    for (int k = 1; k <= 200; k++) begin
      selector = (k % 2 == 1);
      tick();
      checkCount++;
      if (busy !== 1'b1 || i !== W'(200 - k) || int'(a) + int'(b) != 3 * int'(i) || i > n) begin
        errCount++;
        $display("[TB] FAIL long_step%0d: busy=%b a=%0d b=%0d i=%0d, required busy=1 i=%0d a+b=3i", k, busy, a, b, i, 200 - k);
      end
      if (k % 2 == 0) begin
        checkCount++;
        if (a !== W'(300 - 3 * (k / 2)) || b !== W'(300 - 3 * (k / 2))) begin
          errCount++;
          $display("[TB] FAIL long_pair%0d: a=%0d b=%0d, required %0d each", k, a, b, 300 - 3 * (k / 2));
        end
      end else if (k == 1) begin
        checkCount++;
        if (a !== 299 || b !== 298) begin
          errCount++;
          $display("[TB] FAIL long_first: a=%0d b=%0d, required 299 298", a, b);
        end
      end
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b010 || a !== 0 || b !== 0 || i !== 0 || n !== 200) begin
      errCount++;
      $display("[TB] FAIL long_done: flags=%b a=%0d b=%0d i=%0d n=%0d, required 010 0 0 0 200", {busy, done, err}, a, b, i, n);
    end
  endtask

  task automatic test_bad_sum();
    applyStimulus(5, 5, 3, 1'b1);
    checkCount++;
    if ({busy, done, err} !== 3'b001 || a !== 5 || b !== 5 || i !== 3) begin
      errCount++;
      $display("[TB] FAIL bad_sum: flags=%b a=%0d b=%0d i=%0d, required 001 5 5 3", {busy, done, err}, a, b, i);
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b001 || a !== 5 || i !== 3) begin
      errCount++;
      $display("[TB] FAIL err_hold: flags=%b a=%0d i=%0d, required 001 5 3", {busy, done, err}, a, i);
    end
  endtask

  task automatic test_stuck();
    applyStimulus(0, 6, 2, 1'b1);
    checkCount++;
    if ({busy, done, err} !== 3'b100) begin
      errCount++;
      $display("[TB] FAIL stuck_load: flags=%b, required 100", {busy, done, err});
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b001 || a !== 0 || b !== 6 || i !== 2) begin
      errCount++;
      $display("[TB] FAIL stuck_err: flags=%b a=%0d b=%0d i=%0d, required 001 0 6 2", {busy, done, err}, a, b, i);
    end
  endtask

  task automatic test_fallback();
    applyStimulus(1, 5, 2, 1'b0);
    tick();
    checkCount++;
    if (busy !== 1'b1 || a !== 0 || b !== 3 || i !== 1) begin
      errCount++;
      $display("[TB] FAIL fallback_step: busy=%b a=%0d b=%0d i=%0d, required 1 0 3 1", busy, a, b, i);
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b001 || a !== 0 || b !== 3 || i !== 1) begin
      errCount++;
      $display("[TB] FAIL fallback_err: flags=%b a=%0d b=%0d i=%0d, required 001 0 3 1", {busy, done, err}, a, b, i);
    end
    applyStimulus(3, 3, 2, 1'b0);
    tick();
    checkCount++;
    if (a !== 1 || b !== 2 || i !== 1) begin
      errCount++;
      $display("[TB] FAIL pref_step: a=%0d b=%0d i=%0d, required 1 2 1", a, b, i);
    end
    tick();
    checkCount++;
    if (busy !== 1'b1 || a !== 0 || b !== 0 || i !== 0) begin
      errCount++;
      $display("[TB] FAIL fallback_zero: busy=%b a=%0d b=%0d i=%0d, required 1 0 0 0", busy, a, b, i);
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b010) begin
      errCount++;
      $display("[TB] FAIL fallback_done: flags=%b, required 010", {busy, done, err});
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 0, 0, 1'b1);
    checkCount++;
    if ({busy, done, err} !== 3'b100 || i !== 0) begin
      errCount++;
      $display("[TB] FAIL zero_run: flags=%b i=%0d, required 100 0", {busy, done, err}, i);
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b010) begin
      errCount++;
      $display("[TB] FAIL zero_done: flags=%b, required 010", {busy, done, err});
    end
    applyStimulus(6, 6, 4, 1'b1);
    a_in = W'(9);
    b_in = W'(0);
    n_in = W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkCount++;
    if (busy !== 1'b1 || a !== 5 || b !== 4 || i !== 3 || n !== 4) begin
      errCount++;
      $display("[TB] FAIL start_ignored: busy=%b a=%0d b=%0d i=%0d n=%0d, required 1 5 4 3 4", busy, a, b, i, n);
    end
    for (int k = 2; k <= 4; k++) begin
      selector = (k % 2 == 1);
      tick();
    end
    checkCount++;
    if (a !== 0 || b !== 0 || i !== 0 || busy !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL restart_zero: a=%0d b=%0d i=%0d busy=%b, required 0 0 0 1", a, b, i, busy);
    end
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b010 || n !== 4) begin
      errCount++;
      $display("[TB] FAIL restart_done: flags=%b n=%0d, required 010 4", {busy, done, err}, n);
    end
  endtask

  task automatic test_reset_midrun();
    applyStimulus(300, 300, 200, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      selector = (k % 2 == 1);
      tick();
    end
    checkCount++;
    if (i !== 100 || busy !== 1'b1 || a !== 150) begin
      errCount++;
      $display("[TB] FAIL mid_state: i=%0d busy=%b a=%0d, required 100 1 150", i, busy, a);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkCount++;
    if ({a, b, n, i} !== {4 * W{1'b0}} || {busy, done, err} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL mid_reset: a=%0d b=%0d n=%0d i=%0d flags=%b, required all 0", a, b, n, i, {busy, done, err});
    end
    tick();
    tick();
    checkCount++;
    if ({busy, done, err} !== 3'b000 || i !== 0) begin
      errCount++;
      $display("[TB] FAIL no_resume: flags=%b i=%0d, required 000 0", {busy, done, err}, i);
    end
    applyStimulus(3, 3, 2, 1'b0);
    checkCount++;
    if (busy !== 1'b1 || a !== 3 || b !== 3 || n !== 2 || i !== 2) begin
      errCount++;
      $display("[TB] FAIL reload: busy=%b a=%0d b=%0d n=%0d i=%0d, required 1 3 3 2 2", busy, a, b, n, i);
    end
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst        = 1'b1;
    start      = 1'b0;
    a_in       = '0;
    b_in       = '0;
    n_in       = '0;
    selector   = 1'b0;
    #1;
    test_reset();
    test_long_run();
    test_bad_sum();
    test_stuck();
    test_fallback();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
